// File: rtl/spi_mst.sv
// SPI master for the resolver's 16-bit slave port: SCLK idles high, MSB first, MISO sampled at
// each SCLK fall. Optional build macro SPI_MST_MISO_SYNC_EN adds a 2-flop MISO synchronizer.
module spi_mst #(
  parameter int unsigned SCLK_DIV    = 32,
  parameter int unsigned FRONT_PORCH = 16,
  parameter int unsigned BACK_PORCH  = 16,
  parameter int unsigned GAP         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int unsigned HALF  = SCLK_DIV / 2;
  localparam int unsigned MAX_A = (SCLK_DIV > FRONT_PORCH) ? SCLK_DIV : FRONT_PORCH;
  localparam int unsigned MAX_B = (BACK_PORCH > GAP) ? BACK_PORCH : GAP;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] FRONT_END = CW'(FRONT_PORCH - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(HALF - 1);
  localparam logic [CW-1:0] BACK_END  = CW'(BACK_PORCH - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFront,
    StLow,
    StHigh,
    StBack,
    StGap
  } state_e;

  state_e        state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  // Bit 15 of the command goes straight to MOSI at load, so only bits 14:0 are kept.
  logic [14:0]   tx_shft;
  logic [15:0]   rx_shft;
  logic          miso_s;

`ifdef SPI_MST_MISO_SYNC_EN
  logic miso_ff1, miso_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_ff1 <= 1'b0;
      miso_ff2 <= 1'b0;
    end else begin
      miso_ff1 <= MISO;
      miso_ff2 <= miso_ff1;
    end
  end

  assign miso_s = miso_ff2;
`else
  assign miso_s = MISO;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_shft <= '0;
      rx_shft <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      SS_n    <= 1'b1;
      SCLK    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (wrt) begin
            tx_shft <= cmd[14:0];
            MOSI    <= cmd[15];
            SS_n    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= StFront;
          end
        end
        StFront: begin
          if (div_cnt == FRONT_END) begin
            div_cnt <= '0;
            SCLK    <= 1'b0;
            rx_shft <= {rx_shft[14:0], miso_s};
            state   <= StLow;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        StLow: begin
          if (div_cnt == HALF_END) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            bit_cnt <= bit_cnt + 5'd1;
            // The 16th rise has no further bit to present.
            if (bit_cnt != 5'd15) begin
              MOSI    <= tx_shft[14];
              tx_shft <= {tx_shft[13:0], 1'b0};
            end
            state <= StHigh;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        StHigh: begin
          if (div_cnt == HALF_END) begin
            div_cnt <= '0;
            if (bit_cnt == 5'd16) begin
              state <= StBack;
            end else begin
              SCLK    <= 1'b0;
              rx_shft <= {rx_shft[14:0], miso_s};
              state   <= StLow;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        StBack: begin
          if (div_cnt == BACK_END) begin
            div_cnt <= '0;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
            rd_data <= rx_shft;
            done    <= 1'b1;
            state   <= StGap;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        StGap: begin
          if (div_cnt == GAP_END) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mst.sv
// Randomized scoreboard bench for spi_mst: a behavioural slave plus an arithmetic pin-timing model.
module tb_spi_mst;

  localparam int FP      = 16;
  localparam int DIV     = 32;
  localparam int BP      = 16;
  localparam int GAPC    = 16;
  localparam int FRAME   = FP + 16 * DIV + BP;   // SS_n low cycles
  localparam int BUSY_N  = FRAME + GAPC;         // busy high cycles

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [15:0] cmd;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  spi_mst dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  typedef struct {
    logic [15:0] rd;
    logic [15:0] cmd;
    int          cyc;
  } exp_t;

  exp_t        scb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_k = -100000;
  logic        valid = 1'b0;
  logic [15:0] cmd_last = '0;

  // Behavioural slave state
  logic        loop = 1'b0;
  logic [15:0] slv_resp = '0;
  logic [15:0] slv_rcv = '0;
  logic        miso_r = 1'b0;
  int          fall_cnt = 0;
  int          upd_at = -1;
  logic        sclk_prev = 1'b1;
  logic        ss_prev = 1'b1;

  assign MISO = loop ? MOSI : miso_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Slave: shifts MOSI in at each fall, presents next response bit 3 clocks after the fall.
  initial begin
    forever begin
      @(negedge clk);
      if (ss_prev && !SS_n) begin
        fall_cnt = 0;
        slv_rcv  = '0;
      end
      if (SS_n) begin
        miso_r = slv_resp[15];
      end else if (sclk_prev && !SCLK) begin
        slv_rcv  = {slv_rcv[14:0], MOSI};
        fall_cnt = fall_cnt + 1;
        upd_at   = cyc + 3;
      end else if (cyc == upd_at && fall_cnt < 16) begin
        miso_r = slv_resp[15-fall_cnt];
      end
      sclk_prev = SCLK;
      ss_prev   = SS_n;
    end
  end

  // Monitor: pin timing against the frame model, and done against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      int   p;
      int   q;
      logic e_busy, e_ss, e_sclk, e_mosi, e_done;
      p      = cyc - (last_k + 1);
      e_busy = valid && p >= 0 && p < BUSY_N;
      e_ss   = !(valid && p >= 0 && p < FRAME);
      e_sclk = !(!e_ss && p >= FP && p < FP + 16 * DIV && ((p - FP) % DIV) < DIV / 2);
      q      = (p / DIV > 15) ? 15 : p / DIV;
      e_mosi = e_ss ? 1'b0 : cmd_last[15-q];
      e_done = valid && p == FRAME;
      check("pins{busy,ss,sclk,mosi,done}", {27'd0, busy, SS_n, SCLK, MOSI, done},
            {27'd0, e_busy, e_ss, e_sclk, e_mosi, e_done});
      if (done) begin
        if (scb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = scb.pop_front();
          check("rd_data", {16'd0, rd_data}, {16'd0, e.rd});
          check("slave_cmd", {16'd0, slv_rcv}, {16'd0, e.cmd});
          check("done_cycle", cyc, e.cyc);
          check("fall_count", fall_cnt, 16);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_free();
    wait_until(last_k + BUSY_N + 1);
  endtask

  // One-cycle wrt pulse; the model decides acceptance from its own busy window.
  task automatic pulse_wrt(input logic [15:0] c, input logic [15:0] resp, input logic lp);
    if (!valid || cyc >= last_k + BUSY_N + 1) begin
      exp_t e;
      loop     = lp;
      slv_resp = resp;
      last_k   = cyc;
      valid    = 1'b1;
      cmd_last = c;
      e.rd     = lp ? c : resp;
      e.cmd    = c;
      e.cyc    = cyc + FRAME + 1;
      scb.push_back(e);
    end
    wrt = 1'b1;
    cmd = c;
    step();
    wrt = 1'b0;
  endtask

  task automatic check_idle_pins(input string name);
    check(name, {11'd0, SS_n, SCLK, MOSI, busy, done, rd_data},
          {11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wrt   = 1'b0;
    cmd   = '0;
    repeat (3) @(negedge clk);
    check_idle_pins("reset_state");
    #2 rst_n = 1'b1;
    step();

    pulse_wrt(16'hA5C3, 16'h0000, 1'b1);
    wait_free();
    pulse_wrt(16'h1234, 16'h0ABC, 1'b0);
    wait_free();

    // wrt during busy, including the cycle busy falls, must be ignored
    pulse_wrt(16'h5A0F, 16'h3C3C, 1'b0);
    wait_until(last_k + 100);
    pulse_wrt(16'hFFFF, 16'hFFFF, 1'b0);
    wait_until(last_k + 300);
    pulse_wrt(16'hFFFF, 16'hFFFF, 1'b0);
    wait_until(last_k + BUSY_N);
    pulse_wrt(16'hFFFF, 16'hFFFF, 1'b0);
    pulse_wrt(16'($urandom), 16'($urandom), 1'b0);   // first !busy cycle

    for (int i = 0; i < 6; i++) begin
      wait_free();
      repeat ($urandom_range(0, 20)) step();
      pulse_wrt(16'($urandom), 16'($urandom), 1'b0);
    end
    wait_free();

    // Reset in the low phase of bit 7
    pulse_wrt(16'hC0DE, 16'h7777, 1'b0);
    wait_until(last_k + 1 + FP + 7 * DIV + 5);
    rst_n = 1'b0;
    valid = 1'b0;
    scb.delete();
    #1;
    check_idle_pins("midframe_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    pulse_wrt(16'h8001, 16'h4321, 1'b0);
    wait_free();
    repeat (5) step();
    check("scoreboard_empty", scb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
